// File: rtl/fetch_queue_if.sv
// fetch_queue_if: handshake bundle around the instruction fetch queue.
//   PC side    : flush, pc_valid, pc_in, pc_ready
//   Memory side: imem_req, imem_addr, imem_gnt, imem_rvalid, imem_rdata
//   Decode side: id_valid, id_instr, id_pc, id_ready
// modport master : the fetch queue itself (drives requests and decode outputs)
// modport slave  : the surrounding PC stage, memory and decode
interface fetch_queue_if #(
   parameter int AW = 8,
   parameter int IW = 32
);
   logic          flush;
   logic          pc_valid;
   logic [AW-1:0] pc_in;
   logic          pc_ready;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [IW-1:0] imem_rdata;
   logic          id_valid;
   logic [IW-1:0] id_instr;
   logic [AW-1:0] id_pc;
   logic          id_ready;

   modport master (
      input  flush, pc_valid, pc_in, imem_gnt, imem_rvalid, imem_rdata, id_ready,
      output pc_ready, imem_req, imem_addr, id_valid, id_instr, id_pc
   );

   modport slave (
      output flush, pc_valid, pc_in, imem_gnt, imem_rvalid, imem_rdata, id_ready,
      input  pc_ready, imem_req, imem_addr, id_valid, id_instr, id_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch stage between the PC stage and decode.
// Takes fetch addresses (pc_valid/pc_ready), issues them to instruction memory
// over req/gnt with in-order rvalid responses, and buffers {pc, instr} pairs for
// decode. A flush discards everything queued and turns every in-flight response
// into one to be dropped.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   bus          fetch_queue_if.master (PC, memory and decode handshakes)
//   perf_fetched instructions consumed by decode     (FETCH_QUEUE_PERF_EN only)
//   perf_stall   cycles with pc_valid & ~pc_ready    (FETCH_QUEUE_PERF_EN only)
// Optional feature macro: FETCH_QUEUE_PERF_EN
//
// state | meaning
// RUN   | no stale responses pending; rvalid data is pushed to the instr FIFO
// DRAIN | drop > 0; next rvalid belongs to a flushed fetch and is discarded
module fetch_queue #(
   parameter int AW    = 8,
   parameter int IW    = 32,
   parameter int DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst,
   fetch_queue_if.master  bus
`ifdef FETCH_QUEUE_PERF_EN
   ,
   output logic [31:0]    perf_fetched,
   output logic [31:0]    perf_stall
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] occ_q, occ_d, outst_q, outst_d, drop_q, drop_d;
   logic [PW-1:0] a_wr_q, a_wr_d, a_rd_q, a_rd_d;
   logic [PW-1:0] i_wr_q, i_wr_d, i_rd_q, i_rd_d;
   logic [AW-1:0] addr_mem [DEPTH];
   logic [AW-1:0] pc_mem   [DEPTH];
   logic [IW-1:0] ins_mem  [DEPTH];
   logic [CW+1:0] used;
   logic          credit, grant, rv_keep, rv_drop, pop;

   // Every slot is accounted for by a queued entry, an outstanding fetch or a
   // response still to be thrown away; only request when one is free.
   assign used          = {2'b00, occ_q} + {2'b00, outst_q} + {2'b00, drop_q};
   assign credit        = used < (CW+2)'(DEPTH);
   assign bus.imem_req  = bus.pc_valid & credit & ~bus.flush & ~rst;
   assign bus.imem_addr = bus.pc_in;
   assign bus.pc_ready  = bus.imem_req & bus.imem_gnt;
   assign grant         = bus.pc_ready;
   assign bus.id_valid  = (occ_q != '0) & ~bus.flush;
   assign bus.id_pc     = pc_mem[i_rd_q];
   assign bus.id_instr  = ins_mem[i_rd_q];
   assign pop           = bus.id_valid & bus.id_ready;
   assign rv_drop       = bus.imem_rvalid & (state_q == DRAIN);
   // rvalid with nothing outstanding is a protocol error and is ignored
   assign rv_keep       = bus.imem_rvalid & (state_q == RUN) & (outst_q != '0);

   always_comb begin
      occ_d   = occ_q;
      outst_d = outst_q;
      drop_d  = drop_q;
      a_wr_d  = a_wr_q;
      a_rd_d  = a_rd_q;
      i_wr_d  = i_wr_q;
      i_rd_d  = i_rd_q;
      if (bus.flush) begin
         occ_d   = '0;
         outst_d = '0;
         a_wr_d  = '0;
         a_rd_d  = '0;
         i_wr_d  = '0;
         i_rd_d  = '0;
         // a response arriving in the flush cycle retires one stale fetch
         if (bus.imem_rvalid && ((drop_q != '0) || (outst_q != '0)))
            drop_d = drop_q + outst_q - CW'(1);
         else
            drop_d = drop_q + outst_q;
      end else begin
         if (grant)   a_wr_d = a_wr_q + PW'(1);
         if (rv_keep) begin
            a_rd_d = a_rd_q + PW'(1);
            i_wr_d = i_wr_q + PW'(1);
         end
         if (pop)     i_rd_d = i_rd_q + PW'(1);
         occ_d   = occ_q + CW'(rv_keep) - CW'(pop);
         outst_d = outst_q + CW'(grant) - CW'(rv_keep);
         if (rv_drop) drop_d = drop_q - CW'(1);
      end
      state_d = (drop_d != '0) ? DRAIN : RUN;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         occ_q   <= '0;
         outst_q <= '0;
         drop_q  <= '0;
         a_wr_q  <= '0;
         a_rd_q  <= '0;
         i_wr_q  <= '0;
         i_rd_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_mem[i] <= '0;
            pc_mem[i]   <= '0;
            ins_mem[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
         a_wr_q  <= a_wr_d;
         a_rd_q  <= a_rd_d;
         i_wr_q  <= i_wr_d;
         i_rd_q  <= i_rd_d;
         if (grant)
            addr_mem[a_wr_q] <= bus.pc_in;
         if (rv_keep && !bus.flush) begin
            pc_mem[i_wr_q]  <= addr_mem[a_rd_q];
            ins_mem[i_wr_q] <= bus.imem_rdata;
         end
      end
   end

`ifdef FETCH_QUEUE_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (pop)                          perf_fetched <= perf_fetched + 32'd1;
         if (bus.pc_valid && !bus.pc_ready) perf_stall  <= perf_stall + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
   localparam int AW = 8, IW = 32, DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fetch_queue_if #(.AW(AW), .IW(IW)) bus ();
`ifdef FETCH_QUEUE_PERF_EN
   logic [31:0] perf_fetched, perf_stall;
`endif

   fetch_queue #(.AW(AW), .IW(IW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef FETCH_QUEUE_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_stall   (perf_stall)
`endif
   );

   int total = 0, bad = 0;
   int cyc = 0;
   int lat_max = 0;

   // reference model: granted addresses awaiting data, stale responses, decode FIFO
   logic [AW-1:0]    m_infl[$];
   int               m_drop = 0;
   logic [AW+IW-1:0] m_fifo[$];
   int               m_fetched = 0, m_stall = 0;

   // memory model: in-order pending responses and the cycle each may return
   logic [AW-1:0] mem_q[$];
   int            mem_due[$];

   // DUT-observed events for the directed literal checks
   logic [AW-1:0] dpop_pc[$];
   int            dpop_cyc[$];
   logic [AW-1:0] dgrant_pc[$];
   bit            last_idv;

   function automatic logic [IW-1:0] mem_data(input logic [AW-1:0] a);
      return ({24'h0, a} * 32'h0100_0193) ^ 32'hdead_beef;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input bit pv, input logic [AW-1:0] pc, input bit gnt, input bit rv_try,
                       input bit idr, input bit fl, input bit spur, output bit rdy);
      bit rv, credit, e_req, e_idv;
      logic [IW-1:0] rd;
      @(negedge clk);
      rv = spur || (rv_try && mem_q.size() != 0 && mem_due[0] <= cyc);
      rd = (rv && mem_q.size() != 0) ? mem_data(mem_q[0]) : IW'($urandom);
      bus.flush       = fl;
      bus.pc_valid    = pv;
      bus.pc_in       = pc;
      bus.imem_gnt    = gnt;
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rd;
      bus.id_ready    = idr;
      #1;
      credit = (m_fifo.size() + m_infl.size() + m_drop) < DEPTH;
      e_req  = pv && credit && !fl;
      rdy    = e_req && gnt;
      e_idv  = m_fifo.size() != 0 && !fl;
      check("imem_req", 64'(bus.imem_req), 64'(e_req));
      check("pc_ready", 64'(bus.pc_ready), 64'(rdy));
      if (e_req) check("imem_addr", 64'(bus.imem_addr), 64'(pc));
      check("id_valid", 64'(bus.id_valid), 64'(e_idv));
      if (e_idv) begin
         check("id_pc", 64'(bus.id_pc), 64'(m_fifo[0][AW+IW-1:IW]));
         check("id_instr", 64'(bus.id_instr), 64'(m_fifo[0][IW-1:0]));
      end
      last_idv = bus.id_valid;
      if (bus.id_valid && idr) begin
         dpop_pc.push_back(bus.id_pc);
         dpop_cyc.push_back(cyc);
      end
      if (bus.pc_ready) dgrant_pc.push_back(bus.imem_addr);
      if (pv && !rdy) m_stall++;
      if (rv && mem_q.size() != 0) begin
         void'(mem_q.pop_front());
         void'(mem_due.pop_front());
      end
      if (rdy) begin
         mem_q.push_back(pc);
         mem_due.push_back(cyc + 1 + $urandom_range(0, lat_max));
      end
      if (fl) begin
         if (rv && (m_drop + m_infl.size()) != 0) m_drop = m_drop + m_infl.size() - 1;
         else                                     m_drop = m_drop + m_infl.size();
         m_infl.delete();
         m_fifo.delete();
      end else begin
         if (e_idv && idr) begin
            void'(m_fifo.pop_front());
            m_fetched++;
         end
         if (rv) begin
            if (m_drop > 0) m_drop--;
            else if (m_infl.size() != 0) begin
               m_fifo.push_back({m_infl[0], rd});
               void'(m_infl.pop_front());
            end
         end
         if (rdy) m_infl.push_back(pc);
      end
      cyc++;
   endtask

   task automatic do_reset(input bit pv);
      @(negedge clk);
      rst             = 1'b1;
      bus.flush       = 1'b0;
      bus.pc_valid    = pv;
      bus.pc_in       = 8'h33;
      bus.imem_gnt    = 1'b1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.id_ready    = 1'b0;
      @(posedge clk);
      #1;
      check("rst_imem_req", 64'(bus.imem_req), 64'd0);
      check("rst_pc_ready", 64'(bus.pc_ready), 64'd0);
      check("rst_id_valid", 64'(bus.id_valid), 64'd0);
      check("rst_id_pc", 64'(bus.id_pc), 64'd0);
      check("rst_id_instr", 64'(bus.id_instr), 64'd0);
      @(negedge clk);
      rst          = 1'b0;
      bus.pc_valid = 1'b0;
      bus.imem_gnt = 1'b0;
      m_infl.delete();
      m_fifo.delete();
      m_drop = 0;
      m_fetched = 0;
      m_stall = 0;
      mem_q.delete();
      mem_due.delete();
      dpop_pc.delete();
      dpop_cyc.delete();
      dgrant_pc.delete();
      cyc += 2;
   endtask

   task automatic setup_2out_1q();
      bit r;
      step(1, 8'h00, 1, 0, 0, 0, 0, r);
      step(1, 8'h01, 1, 1, 0, 0, 0, r);
      step(1, 8'h02, 1, 0, 0, 0, 0, r);
   endtask

   initial begin
      bit r;
      logic [AW-1:0] pc;
      int t0;
      rst = 1'b1;

      // 1: stream pc 0..7, one instruction per cycle with no gaps
      do_reset(1'b1);
      t0 = cyc;
      for (int i = 0; i < 8; i++) step(1, AW'(i), 1, 1, 1, 0, 0, r);
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 1, 1, 0, 0, r);
      check("stream_count", 64'(dpop_pc.size()), 64'd8);
      for (int i = 0; i < 8 && i < dpop_pc.size(); i++) begin
         check("stream_pc", 64'(dpop_pc[i]), 64'(i));
         check("stream_cycle", 64'(dpop_cyc[i]), 64'(t0 + 2 + i));
      end

      // 2: decode stalled -> exactly DEPTH grants, then resume at pc 4
      do_reset(1'b0);
      pc = 8'h00;
      for (int i = 0; i < 8; i++) begin
         step(1, pc, 1, 1, 0, 0, 0, r);
         if (r) pc++;
      end
      check("bp_grants", 64'(dgrant_pc.size()), 64'd4);
      for (int i = 0; i < 6; i++) begin
         step(1, pc, 1, 1, 1, 0, 0, r);
         if (r) pc++;
      end
      check("bp_resume_more", 64'(dgrant_pc.size() > 4), 64'd1);
      if (dgrant_pc.size() > 4) check("bp_resume_pc", 64'(dgrant_pc[4]), 64'h04);

      // 3: flush with 2 outstanding and 1 queued, redirect to 0x40
      do_reset(1'b0);
      setup_2out_1q();
      step(1, 8'h40, 1, 0, 1, 1, 0, r);
      step(1, 8'h40, 1, 1, 1, 0, 0, r);
      check("flush_idv_next", 64'(last_idv), 64'd0);
      for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 1, 1, 0, 0, r);
      check("flush_count", 64'(dpop_pc.size()), 64'd1);
      if (dpop_pc.size() > 0) check("flush_first_pc", 64'(dpop_pc[0]), 64'h40);

      // 4: flush coinciding with rvalid and id_ready -> drop = outst-1
      do_reset(1'b0);
      setup_2out_1q();
      step(0, 8'h00, 1, 1, 1, 1, 0, r);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 1, 1, 0, 0, r);
      check("flush_rv_none", 64'(dpop_pc.size()), 64'd0);
      step(1, 8'h80, 1, 1, 1, 0, 0, r);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 1, 1, 0, 0, r);
      check("flush_rv_after", 64'(dpop_pc.size()), 64'd1);
      if (dpop_pc.size() > 0) check("flush_rv_pc", 64'(dpop_pc[0]), 64'h80);

      // 5: grant held low for 3 cycles -> one request on grant
      do_reset(1'b0);
      for (int i = 0; i < 3; i++) step(1, 8'h10, 0, 1, 1, 0, 0, r);
      step(1, 8'h10, 1, 1, 1, 0, 0, r);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 1, 1, 0, 0, r);
      check("gnt_low_grants", 64'(dgrant_pc.size()), 64'd1);
      check("gnt_low_pops", 64'(dpop_pc.size()), 64'd1);

      // stray rvalid with nothing outstanding is ignored
      step(0, 8'h00, 0, 0, 1, 0, 1, r);
      step(0, 8'h00, 0, 0, 1, 0, 0, r);
      check("spurious_rv", 64'(last_idv), 64'd0);

      // 6: reset with 2 outstanding, then a clean fetch from pc 0
      step(1, 8'h00, 1, 0, 0, 0, 0, r);
      step(1, 8'h01, 1, 0, 0, 0, 0, r);
      do_reset(1'b1);
      for (int i = 0; i < 4; i++) step(1, AW'(i), 1, 1, 1, 0, 0, r);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 1, 1, 0, 0, r);
      check("post_rst_count", 64'(dpop_pc.size()), 64'd4);
      for (int i = 0; i < 4 && i < dpop_pc.size(); i++)
         check("post_rst_pc", 64'(dpop_pc[i]), 64'(i));

      // random traffic against the model
      pc = 8'h00;
      for (int i = 0; i < 4000; i++) begin
         bit fl;
         if ($urandom_range(0, 599) == 0) do_reset($urandom_range(0, 1) == 1);
         lat_max = $urandom_range(0, 2);
         fl = ($urandom_range(0, 24) == 0);
         step($urandom_range(0, 3) != 0, pc, $urandom_range(0, 3) != 0,
              $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, fl,
              (mem_q.size() == 0) && ($urandom_range(0, 99) == 0), r);
         if (fl)     pc = AW'($urandom);
         else if (r) pc++;
      end

`ifdef FETCH_QUEUE_PERF_EN
      check("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
      check("perf_stall", 64'(perf_stall), 64'(m_stall));
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
